// File: rtl/router_pkg.sv
// Shared router definitions: header layout {payload_len, addr}, header helpers
// and the packet reader state encoding.
package router_pkg;

  localparam int BYTE_W = 8;
  localparam int ADDR_W = 2;
  localparam int LEN_W  = 6;

  typedef enum logic [2:0] {
    IDLE,
    HDR,
    PAYLOAD,
    PARITY,
    DONE
  } state_t;

  function automatic logic [LEN_W-1:0] hdr_len(input logic [BYTE_W-1:0] hdr);
    return hdr[BYTE_W-1:ADDR_W];
  endfunction

  function automatic logic [ADDR_W-1:0] hdr_addr(input logic [BYTE_W-1:0] hdr);
    return hdr[ADDR_W-1:0];
  endfunction

  function automatic logic [BYTE_W-1:0] make_hdr(input logic [LEN_W-1:0]  len,
                                                 input logic [ADDR_W-1:0] addr);
    return {len, addr};
  endfunction

endpackage

// File: rtl/router_pkt_reader_if.sv
// FIFO read port plus downstream payload stream of one router output port.
interface router_pkt_reader_if;
  import router_pkg::*;

  logic              fifo_empty;
  logic [BYTE_W-1:0] fifo_dout;
  logic              fifo_re;

  logic [BYTE_W-1:0] out_data;
  logic              out_valid;
  logic              out_sop;
  logic              out_eop;
  logic              out_ready;

  modport master (
    input  fifo_empty, fifo_dout, out_ready,
    output fifo_re, out_data, out_valid, out_sop, out_eop
  );

  modport slave (
    output fifo_empty, fifo_dout, out_ready,
    input  fifo_re, out_data, out_valid, out_sop, out_eop
  );

endinterface

// File: rtl/router_sat_cnt.sv
// Saturating up-counter with increment enable; sticks at all-ones.
module router_sat_cnt #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] count_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_reg <= '0;
    end else if (inc && (count_reg != {W{1'b1}})) begin
      count_reg <= count_reg + W'(1);
    end
  end

  assign count = count_reg;

endmodule

// File: rtl/router_pkt_reader.sv
// Drains one router output FIFO, parses header/payload/parity framing, streams
// the payload downstream and reports per-packet length, parity and address status.
module router_pkt_reader
  import router_pkg::*;
#(
  parameter logic [ADDR_W-1:0] PORT_ID = 2'd0,
  parameter int                CNT_W   = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  router_pkt_reader_if.master  bus,
  output logic                 pkt_done,
  output logic [LEN_W-1:0]     pkt_len,
  output logic                 parity_err,
  output logic                 addr_err,
  output logic                 busy,
  output logic [CNT_W-1:0]     pkt_cnt,
  output logic [CNT_W-1:0]     err_cnt
);

  state_t             state_reg, state_next;
  logic               rd_pend_reg;
  logic [LEN_W-1:0]   len_reg, len_next;
  logic [LEN_W-1:0]   rem_reg, rem_next;
  logic [ADDR_W-1:0]  addr_reg, addr_next;
  logic [BYTE_W-1:0]  acc_reg, acc_next;
  logic [BYTE_W-1:0]  out_data_reg, out_data_next;
  logic               out_valid_reg, out_valid_next;
  logic               out_sop_reg, out_sop_next;
  logic               out_eop_reg, out_eop_next;
  logic [LEN_W-1:0]   pkt_len_reg, pkt_len_next;
  logic               parity_err_reg, parity_err_next;
  logic               addr_err_reg, addr_err_next;

  logic               need_byte;
  logic               out_free;
  logic               accept;
  logic               fifo_re;
  logic [BYTE_W-1:0]  dout;

  assign dout     = bus.fifo_dout;
  assign accept   = out_valid_reg && bus.out_ready;
  assign out_free = !out_valid_reg || bus.out_ready;

  // The parity byte is only fetched once the last payload byte has left the
  // output register, so DONE can never precede the eop handshake.
  always_comb begin
    need_byte = 1'b0;
    case (state_reg)
      IDLE:    need_byte = 1'b1;
      PAYLOAD: need_byte = 1'b1;
      PARITY:  need_byte = !out_valid_reg;
      default: need_byte = 1'b0;
    endcase
  end

  assign fifo_re = !rst && need_byte && !bus.fifo_empty && !rd_pend_reg &&
                   ((state_reg != PAYLOAD) || out_free);

  always_comb begin
    state_next      = state_reg;
    len_next        = len_reg;
    rem_next        = rem_reg;
    addr_next       = addr_reg;
    acc_next        = acc_reg;
    out_data_next   = out_data_reg;
    out_valid_next  = accept ? 1'b0 : out_valid_reg;
    out_sop_next    = out_sop_reg;
    out_eop_next    = out_eop_reg;
    pkt_len_next    = pkt_len_reg;
    parity_err_next = parity_err_reg;
    addr_err_next   = addr_err_reg;

    case (state_reg)
      IDLE: begin
        if (fifo_re) begin
          state_next = HDR;
        end
      end

      HDR: begin
        if (rd_pend_reg) begin
          len_next   = hdr_len(dout);
          addr_next  = hdr_addr(dout);
          rem_next   = hdr_len(dout);
          acc_next   = dout;
          state_next = (hdr_len(dout) == '0) ? PARITY : PAYLOAD;
        end
      end

      PAYLOAD: begin
        if (rd_pend_reg) begin
          out_data_next  = dout;
          out_valid_next = 1'b1;
          out_sop_next   = (rem_reg == len_reg);
          out_eop_next   = (rem_reg == LEN_W'(1));
          acc_next       = acc_reg ^ dout;
          rem_next       = rem_reg - LEN_W'(1);
          if (rem_reg == LEN_W'(1)) begin
            state_next = PARITY;
          end
        end
      end

      PARITY: begin
        if (rd_pend_reg) begin
          parity_err_next = (acc_reg != dout);
          addr_err_next   = (addr_reg != PORT_ID);
          pkt_len_next    = len_reg;
          state_next      = DONE;
        end
      end

      DONE: begin
        state_next = IDLE;
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg      <= IDLE;
      rd_pend_reg    <= 1'b0;
      len_reg        <= '0;
      rem_reg        <= '0;
      addr_reg       <= '0;
      acc_reg        <= '0;
      out_data_reg   <= '0;
      out_valid_reg  <= 1'b0;
      out_sop_reg    <= 1'b0;
      out_eop_reg    <= 1'b0;
      pkt_len_reg    <= '0;
      parity_err_reg <= 1'b0;
      addr_err_reg   <= 1'b0;
    end else begin
      state_reg      <= state_next;
      rd_pend_reg    <= fifo_re;
      len_reg        <= len_next;
      rem_reg        <= rem_next;
      addr_reg       <= addr_next;
      acc_reg        <= acc_next;
      out_data_reg   <= out_data_next;
      out_valid_reg  <= out_valid_next;
      out_sop_reg    <= out_sop_next;
      out_eop_reg    <= out_eop_next;
      pkt_len_reg    <= pkt_len_next;
      parity_err_reg <= parity_err_next;
      addr_err_reg   <= addr_err_next;
    end
  end

  router_sat_cnt #(.W(CNT_W)) u_pkt_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (pkt_done),
    .count (pkt_cnt)
  );

  router_sat_cnt #(.W(CNT_W)) u_err_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (pkt_done && (parity_err_reg || addr_err_reg)),
    .count (err_cnt)
  );

  assign bus.fifo_re   = fifo_re;
  assign bus.out_data  = out_data_reg;
  assign bus.out_valid = out_valid_reg;
  assign bus.out_sop   = out_sop_reg;
  assign bus.out_eop   = out_eop_reg;

  assign pkt_done   = (state_reg == DONE);
  assign pkt_len    = pkt_len_reg;
  assign parity_err = parity_err_reg;
  assign addr_err   = addr_err_reg;
  assign busy       = (state_reg != IDLE);

endmodule

// File: tb/tb_router_pkt_reader.sv
// Randomised scoreboard bench for router_pkt_reader: a FIFO model feeds packets,
// a monitor checks the payload stream and packet status against a queue model.
module tb_router_pkt_reader;
  import router_pkg::*;

  localparam logic [1:0] PORT  = 2'd2;
  localparam int         CNT_W = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  router_pkt_reader_if bus();

  logic             pkt_done;
  logic [5:0]       pkt_len;
  logic             parity_err;
  logic             addr_err;
  logic             busy;
  logic [CNT_W-1:0] pkt_cnt;
  logic [CNT_W-1:0] err_cnt;

  router_pkt_reader #(.PORT_ID(PORT), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .pkt_done   (pkt_done),
    .pkt_len    (pkt_len),
    .parity_err (parity_err),
    .addr_err   (addr_err),
    .busy       (busy),
    .pkt_cnt    (pkt_cnt),
    .err_cnt    (err_cnt)
  );

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // FIFO model: read data appears the cycle after fifo_re; reset flushes it.
  logic [7:0] fmem [0:4095];
  int         wr_ptr = 0;
  int         rd_ptr = 0;
  logic       starve_force = 1'b0;
  logic       starve_rand;

  assign bus.fifo_empty = (rd_ptr == wr_ptr) || starve_force || starve_rand;

  always @(posedge clk) begin
    if (rst) begin
      rd_ptr        <= wr_ptr;
      bus.fifo_dout <= 8'h00;
    end else if (bus.fifo_re) begin
      bus.fifo_dout <= fmem[rd_ptr % 4096];
      rd_ptr        <= rd_ptr + 1;
    end
  end

  // Downstream ready and random starvation: 0 = on, 1 = random, 2 = off.
  int ready_mode  = 0;
  bit rand_starve = 1'b0;
  initial begin
    bus.out_ready = 1'b1;
    starve_rand   = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0:       bus.out_ready = 1'b1;
        1:       bus.out_ready = ($urandom_range(0, 2) != 0);
        default: bus.out_ready = 1'b0;
      endcase
      starve_rand = rand_starve && ($urandom_range(0, 5) == 0);
    end
  end

  // Reference model: expected payload beats and per-packet status.
  typedef struct {
    logic [7:0] data;
    logic       sop;
    logic       eop;
  } beat_t;

  typedef struct {
    logic [5:0] len;
    logic       perr;
    logic       aerr;
  } pkt_t;

  beat_t      exp_beats[$];
  pkt_t       exp_pkts[$];
  logic [7:0] pl_q[$];
  int         total_pkts = 0;
  int         total_errs = 0;

  task automatic put_byte(input logic [7:0] b);
    fmem[wr_ptr % 4096] = b;
    wr_ptr++;
  endtask

  // Sends header, the bytes in pl_q and a parity byte (XOR of all bytes ^ flip).
  task automatic send_pkt(input logic [1:0] addr, input logic [7:0] flip);
    logic [7:0] hdr;
    logic [7:0] x;
    int         n;
    beat_t      bt;
    pkt_t       pk;
    n   = pl_q.size();
    hdr = {n[5:0], addr};
    x   = hdr;
    put_byte(hdr);
    for (int i = 0; i < n; i++) begin
      x       = x ^ pl_q[i];
      bt.data = pl_q[i];
      bt.sop  = (i == 0);
      bt.eop  = (i == n - 1);
      exp_beats.push_back(bt);
      put_byte(pl_q[i]);
    end
    put_byte(x ^ flip);
    pk.len  = n[5:0];
    pk.perr = ((x ^ flip) != x);
    pk.aerr = (addr != PORT);
    exp_pkts.push_back(pk);
    total_pkts++;
    if (pk.perr || pk.aerr) total_errs++;
  endtask

  task automatic rand_payload(input int n);
    pl_q.delete();
    for (int i = 0; i < n; i++) pl_q.push_back(8'($urandom_range(0, 255)));
  endtask

  task automatic wait_idle(input string name, input int budget);
    int n = 0;
    while ((exp_pkts.size() != 0 || busy || rd_ptr != wr_ptr) && n < budget) begin
      @(posedge clk);
      n++;
    end
    checks++;
    if (n >= budget) begin
      failures++;
      $display("FAIL %s: timeout, %0d packets outstanding expected 0", name, exp_pkts.size());
    end
    repeat (2) @(posedge clk);
  endtask

  // Monitor: stream beats, hold stability, FIFO read rules and packet status.
  int    bytes_seen = 0;
  int    model_pkts = 0;
  int    model_errs = 0;
  logic  prev_hold  = 1'b0;
  logic  prev_re    = 1'b0;
  beat_t prev_beat;

  always @(negedge clk) begin
    beat_t eb;
    pkt_t  ep;
    if (rst) begin
      exp_beats.delete();
      exp_pkts.delete();
      bytes_seen = 0;
      model_pkts = 0;
      model_errs = 0;
      prev_hold  = 1'b0;
      prev_re    = 1'b0;
    end else begin
      if (prev_hold) begin
        chk("hold_stable", {bus.out_valid, bus.out_sop, bus.out_eop, bus.out_data},
            {1'b1, prev_beat.sop, prev_beat.eop, prev_beat.data});
      end
      if (bus.fifo_re) begin
        chk("re_rules", {bus.fifo_empty, prev_re}, 2'b00);
      end
      if (bus.out_valid && bus.out_ready) begin
        if (exp_beats.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL beat: got unexpected byte %0h expected none", bus.out_data);
        end else begin
          eb = exp_beats.pop_front();
          chk("beat", {bus.out_sop, bus.out_eop, bus.out_data}, {eb.sop, eb.eop, eb.data});
        end
        bytes_seen++;
      end
      if (pkt_done) begin
        if (exp_pkts.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL pkt_done: got unexpected pulse expected none");
        end else begin
          ep = exp_pkts.pop_front();
          $display("pkt len=%0d parity_err=%0b addr_err=%0b bytes=%0d",
                   pkt_len, parity_err, addr_err, bytes_seen);
          chk("pkt_len", pkt_len, ep.len);
          chk("pkt_err", {parity_err, addr_err}, {ep.perr, ep.aerr});
          chk("pkt_bytes", bytes_seen, ep.len);
          chk("done_after_eop", bus.out_valid, 1'b0);
          chk("pkt_cnt", pkt_cnt, (model_pkts > 255) ? 255 : model_pkts);
          chk("err_cnt", err_cnt, (model_errs > 255) ? 255 : model_errs);
          model_pkts++;
          if (ep.perr || ep.aerr) model_errs++;
        end
        bytes_seen = 0;
      end
      prev_hold = bus.out_valid && !bus.out_ready;
      prev_beat.data = bus.out_data;
      prev_beat.sop  = bus.out_sop;
      prev_beat.eop  = bus.out_eop;
      prev_re   = bus.fifo_re;
    end
  end

  initial begin
    int n;
    int base;
    int len;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_flags", {bus.fifo_re, bus.out_valid, bus.out_sop, bus.out_eop,
                        pkt_done, parity_err, addr_err, busy}, 8'h00);
    chk("reset_vals", {bus.out_data, 2'b00, pkt_len, pkt_cnt, err_cnt}, 32'h0);
    @(posedge clk);
    #2 rst = 1'b0;

    // Reset mid-PAYLOAD aborts the packet.
    ready_mode = 2;
    rand_payload(10);
    send_pkt(PORT, 8'h00);
    n = 0;
    while (!bus.out_valid && n < 100) begin
      @(posedge clk);
      n++;
    end
    chk("midpkt_reach", (n < 100), 1'b1);
    chk("midpkt_busy", busy, 1'b1);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("midpkt_reset", {bus.fifo_re, bus.out_valid, bus.out_sop, bus.out_eop,
                         pkt_done, parity_err, addr_err, busy}, 8'h00);
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    total_pkts = 0;
    total_errs = 0;
    ready_mode = 0;

    // Directed packets: good, parity error, address error, zero length.
    pl_q = '{8'h11, 8'h22, 8'h33};
    send_pkt(PORT, 8'h00);
    wait_idle("good_pkt", 200);
    chk("good_cnt", {pkt_cnt, err_cnt}, {8'd1, 8'd0});
    pl_q = '{8'h11, 8'h22, 8'h33};
    send_pkt(PORT, 8'h01);
    wait_idle("parity_pkt", 200);
    pl_q = '{8'h11, 8'h22, 8'h33};
    send_pkt(2'd1, 8'h00);
    wait_idle("addr_pkt", 200);
    pl_q.delete();
    send_pkt(PORT, 8'h00);
    wait_idle("zero_pkt", 200);
    chk("directed_cnt", {pkt_cnt, err_cnt}, {8'd4, 8'd2});

    // Backpressure with a 20-cycle starvation mid-payload.
    ready_mode = 1;
    base = wr_ptr;
    rand_payload(14);
    send_pkt(PORT, 8'h00);
    n = 0;
    while (rd_ptr < base + 7 && n < 500) begin
      @(posedge clk);
      n++;
    end
    chk("starve_reach", (n < 500), 1'b1);
    #2 starve_force = 1'b1;
    @(posedge clk);
    base = rd_ptr;
    repeat (20) @(posedge clk);
    chk("starve_hold", {busy, 1'b0, rd_ptr == base}, 3'b101);
    #2 starve_force = 1'b0;
    wait_idle("bp_pkt", 2000);

    // Random back-to-back packets, including the 63-byte maximum.
    rand_starve = 1'b1;
    for (int p = 0; p < 40; p++) begin
      if (p == 0)      len = 63;
      else if (p == 1) len = 1;
      else             len = $urandom_range(0, 63);
      ready_mode = $urandom_range(0, 1);
      rand_payload(len);
      send_pkt(($urandom_range(0, 3) == 0) ? 2'($urandom_range(0, 3)) : PORT,
               ($urandom_range(0, 3) == 0) ? 8'($urandom_range(1, 255)) : 8'h00);
    end
    wait_idle("random_pkts", 40000);
    rand_starve = 1'b0;
    ready_mode  = 0;
    repeat (3) @(posedge clk);
    chk("final_pkt_cnt", pkt_cnt, (total_pkts > 255) ? 255 : total_pkts);
    chk("final_err_cnt", err_cnt, (total_errs > 255) ? 255 : total_errs);
    chk("final_idle", {busy, bus.out_valid}, 2'b00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/router_pkt_reader.md
Name: router_pkt_reader

Overview:
Destination-side consumer of one router output FIFO. It drains bytes through the FIFO read port (empty/re/dout) and parses the packet framing: a header of {payload_len[7:2], addr[1:0]}, payload_len payload bytes, then one parity byte. It streams the payload downstream with valid/ready framing and reports per-packet status: length, parity check and address check. It sits between router_fifo and the destination client, one instance per output port.

Parameters:
PORT_ID, 2'd0, expected addr field; a mismatch raises addr_err.
CNT_W, 8, width of the saturating packet and error counters.

Ports:
clk  in  1  system clock; all logic on rising edge.
rst  in  1  asynchronous, active-high reset.
fifo_empty  in  1  FIFO empty flag.
fifo_dout  in  8  FIFO read data; valid the cycle after fifo_re.
fifo_re  out  1  FIFO read strobe.
out_data  out  8  payload byte.
out_valid  out  1  out_data valid.
out_sop  out  1  first payload byte of packet, qualified by out_valid.
out_eop  out  1  last payload byte of packet, qualified by out_valid.
out_ready  in  1  downstream accepts the byte when out_valid && out_ready.
pkt_done  out  1  one-cycle pulse when the parity byte has been checked.
pkt_len  out  6  payload_len of the last packet; held until the next pkt_done.
parity_err  out  1  valid with pkt_done: computed parity != received parity.
addr_err  out  1  valid with pkt_done: header addr != PORT_ID.
busy  out  1  state != IDLE.
pkt_cnt  out  CNT_W  packets completed, saturating.
err_cnt  out  CNT_W  packets with parity_err or addr_err, saturating.

Behaviour:
- Reset (async, rst=1): state=IDLE; fifo_re, out_valid, out_sop, out_eop, pkt_done, parity_err, addr_err, busy = 0; out_data, pkt_len, pkt_cnt, err_cnt, parity accumulator, remaining-byte count = 0.
- Reset mid-packet aborts the packet. No pkt_done is produced. After reset release the next FIFO byte is treated as a header.
- Read rule: at most one read in flight. rd_pend is fifo_re registered.
- fifo_re = need_byte && !fifo_empty && !rd_pend && (state != PAYLOAD || !out_valid || out_ready). fifo_re is combinational from registers and inputs.
- A byte is consumed in the cycle rd_pend=1. Peak rate is one byte per 2 clocks.
- FSM states: IDLE, HDR, PAYLOAD, PARITY, DONE.
- IDLE: need_byte=1; fifo_re marks the header read; go to HDR.
- HDR, on rd_pend: latch len=dout[7:2] and addr=dout[1:0]; acc=dout; rem=len.
  - len==0: go to PARITY; no payload output, out_sop/out_eop never asserted.
  - otherwise go to PAYLOAD.
- PAYLOAD, on rd_pend: out_data=dout, out_valid=1, out_sop=(rem==len), out_eop=(rem==1); acc^=dout; rem-=1. When rem reaches 0, go to PARITY.
- out_valid holds, with data/sop/eop stable, until out_ready. It clears on accept unless a new byte lands in the same cycle.
- PARITY, on rd_pend: parity_err=(acc!=dout); addr_err=(addr!=PORT_ID); pkt_len=len; go to DONE.
- DONE (1 cycle): pkt_done=1. pkt_cnt+=1 and err_cnt+=(parity_err|addr_err), both saturating at all-ones. Next state is IDLE.
  - DONE is not entered until the final payload byte has been accepted (out_valid==0), so pkt_done never precedes the eop handshake.
- Empty FIFO mid-packet: wait indefinitely with no timeout. State, counts and outputs hold.
- A payload length of 63 is legal, giving a 65-byte packet. rem is 6 bits and does not wrap.
- Errors do not drop data. Payload is forwarded regardless; the client discards on pkt_done with an error.

Decomposition:
- Shared package router_pkg: header field widths (ADDR_W=2, LEN_W=6), the header slicing functions, and the state enum (IDLE/HDR/PAYLOAD/PARITY/DONE). A future header writer reuses the same definitions.
- One sub-module is natural: router_sat_cnt, a parameterised saturating counter with increment enable, used for pkt_cnt and err_cnt. Everything else stays in one module.

Test Plan:
- Reset check: drive rst=1 mid-PAYLOAD -> all outputs 0 immediately, state IDLE. After release, next byte 0x0E (len 3, addr 2) parses as a header.
- Good packet, PORT_ID=2: FIFO holds 0x0E, 0x11, 0x22, 0x33, 0x0E, out_ready=1 -> out bytes 11/22/33 with sop on 11 and eop on 33; pkt_done with pkt_len=3, parity_err=0, addr_err=0; pkt_cnt=1.
- Parity error: same packet with parity byte 0x0F -> payload still forwarded; pkt_done with parity_err=1; err_cnt=1.
- Address error: PORT_ID=1, header 0x0E -> addr_err=1, parity_err=0.
- Zero-length packet: bytes 0x02, 0x02 at PORT_ID=2 -> no out_valid at all; pkt_done with pkt_len=0 and no errors.
- Backpressure and starvation: len-14 packet with out_ready toggling randomly and fifo_empty asserted for 20 cycles mid-payload -> no lost or duplicated bytes; fifo_re never asserts on empty or with rd_pend=1; exactly 14 bytes with one sop/eop; pkt_done only after the eop is accepted.
